// File: rtl/operand_fetch_stage_if.sv
// Bus bundle for the operand fetch stage: decoder issue, register file read,
// writeback snoop and execute handoff. The stage uses 'slave'; its environment uses 'master'.
interface operand_fetch_stage_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
);
  logic            id_valid;
  logic            id_ready;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_rd_we;
  logic [OP_W-1:0] id_op;
  logic [XLEN-1:0] id_imm;

  logic [4:0]      rf_raddr1;
  logic [4:0]      rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            ex_valid;
  logic            ex_ready;
  logic [OP_W-1:0] ex_op;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic            ex_rd_we;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rd_we, id_op, id_imm,
    output id_ready,
    output rf_raddr1, rf_raddr2,
    input  rf_rdata1, rf_rdata2,
    input  wb_valid, wb_rd, wb_data,
    output ex_valid, ex_op, ex_a, ex_b, ex_imm, ex_rd, ex_rd_we,
    input  ex_ready
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rd_we, id_op, id_imm,
    input  id_ready,
    input  rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2,
    output wb_valid, wb_rd, wb_data,
    input  ex_valid, ex_op, ex_a, ex_b, ex_imm, ex_rd, ex_rd_we,
    output ex_ready
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: operand read with writeback bypass, pending-write
// scoreboard for RAW/WAW stalls, and one registered instruction toward execute.
module operand_fetch_stage #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  operand_fetch_stage_if.slave  bus
);

  // One-hot register mask, empty when disabled or when the index is x0.
  function automatic logic [31:0] reg_mask(input logic [4:0] idx, input logic en);
    logic [31:0] m;
    if (en && (idx != 5'd0)) begin
      m = 32'd1 << idx;
    end else begin
      m = 32'd0;
    end
    return m;
  endfunction

  logic [31:0]     pending_q, pending_d;
  logic            ex_valid_q, ex_valid_d;
  logic [OP_W-1:0] ex_op_q, ex_op_d;
  logic [XLEN-1:0] ex_a_q, ex_a_d;
  logic [XLEN-1:0] ex_b_q, ex_b_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            ex_rd_we_q, ex_rd_we_d;

  logic            wb_hit1_s, wb_hit2_s, wb_hit_rd_s;
  logic            hazard_s, id_ready_s, accept_s;
  logic [XLEN-1:0] opnd1_s, opnd2_s;
  logic            rd_we_s;

  // Hazard detection, handshake and operand selection.
  always_comb begin
    wb_hit1_s   = bus.wb_valid && (bus.wb_rd == bus.id_rs1);
    wb_hit2_s   = bus.wb_valid && (bus.wb_rd == bus.id_rs2);
    wb_hit_rd_s = bus.wb_valid && (bus.wb_rd == bus.id_rd);
    rd_we_s     = bus.id_rd_we && (bus.id_rd != 5'd0);

    // A writeback landing this cycle resolves the hazard it would otherwise cause.
    hazard_s = ((bus.id_rs1 != 5'd0) && pending_q[bus.id_rs1] && !wb_hit1_s) ||
               ((bus.id_rs2 != 5'd0) && pending_q[bus.id_rs2] && !wb_hit2_s) ||
               (rd_we_s && pending_q[bus.id_rd] && !wb_hit_rd_s);

    id_ready_s = !hazard_s && (!ex_valid_q || bus.ex_ready);
    accept_s   = bus.id_valid && id_ready_s;

    if (bus.id_rs1 == 5'd0) begin
      opnd1_s = {XLEN{1'b0}};
    end else if (wb_hit1_s) begin
      opnd1_s = bus.wb_data;
    end else begin
      opnd1_s = bus.rf_rdata1;
    end

    if (bus.id_rs2 == 5'd0) begin
      opnd2_s = {XLEN{1'b0}};
    end else if (wb_hit2_s) begin
      opnd2_s = bus.wb_data;
    end else begin
      opnd2_s = bus.rf_rdata2;
    end
  end

  // Scoreboard next state: set wins over a same-cycle clear.
  always_comb begin
    pending_d = ((pending_q & ~reg_mask(bus.wb_rd, bus.wb_valid)) |
                 reg_mask(bus.id_rd, accept_s && bus.id_rd_we)) & ~32'd1;
  end

  // Output register next state: load on accept, drain on handoff, else hold.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_imm_d   = ex_imm_q;
    ex_rd_d    = ex_rd_q;
    ex_rd_we_d = ex_rd_we_q;
    if (accept_s) begin
      ex_valid_d = 1'b1;
      ex_op_d    = bus.id_op;
      ex_a_d     = opnd1_s;
      ex_b_d     = opnd2_s;
      ex_imm_d   = bus.id_imm;
      ex_rd_d    = bus.id_rd;
      ex_rd_we_d = rd_we_s;
    end else if (ex_valid_q && bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= 32'd0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= {OP_W{1'b0}};
      ex_a_q     <= {XLEN{1'b0}};
      ex_b_q     <= {XLEN{1'b0}};
      ex_imm_q   <= {XLEN{1'b0}};
      ex_rd_q    <= 5'd0;
      ex_rd_we_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      ex_rd_q    <= ex_rd_d;
      ex_rd_we_q <= ex_rd_we_d;
    end
  end

  assign bus.id_ready  = id_ready_s;
  assign bus.rf_raddr1 = bus.id_rs1;
  assign bus.rf_raddr2 = bus.id_rs2;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_op     = ex_op_q;
  assign bus.ex_a      = ex_a_q;
  assign bus.ex_b      = ex_b_q;
  assign bus.ex_imm    = ex_imm_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.ex_rd_we  = ex_rd_we_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed-vector bench for operand_fetch_stage with a small register file model.
module tb_operand_fetch_stage;

  logic clk;
  logic reset;
  logic force_ones;
  int   n_vec;
  int   n_err;

  logic [31:0] rf_mem [32];

  operand_fetch_stage_if #(.XLEN(32), .OP_W(4)) bus ();

  operand_fetch_stage #(.XLEN(32), .OP_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: asynchronous read, x0 reads 0, optional forced read 1 value.
  assign bus.rf_rdata1 = force_ones ? 32'hFFFF_FFFF :
                         ((bus.rf_raddr1 == 5'd0) ? 32'd0 : rf_mem[bus.rf_raddr1]);
  assign bus.rf_rdata2 = (bus.rf_raddr2 == 5'd0) ? 32'd0 : rf_mem[bus.rf_raddr2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
    end else if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
      rf_mem[bus.wb_rd] <= bus.wb_data;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [3:0] op, input logic [31:0] imm);
    bus.id_valid = 1'b1;
    bus.id_rs1   = rs1;
    bus.id_rs2   = rs2;
    bus.id_rd    = rd;
    bus.id_rd_we = we;
    bus.id_op    = op;
    bus.id_imm   = imm;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    force_ones = 1'b0;
    reset = 1'b1;
    bus.id_valid = 1'b0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_rd = 5'd0;
    bus.id_rd_we = 1'b0; bus.id_op = 4'd0; bus.id_imm = 32'd0;
    bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    bus.ex_ready = 1'b1;
    tick();
    check_vec("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_vec("rst_ex_a", bus.ex_a, 32'd0);
    check_vec("rst_pending", dut.pending_q, 32'd0);
    reset = 1'b0;

    // Preload x1=5, x2=7 through writeback.
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
    tick();
    bus.wb_rd = 5'd2; bus.wb_data = 32'd7;
    tick();
    bus.wb_valid = 1'b0;

    // Independent issue.
    issue(5'd1, 5'd2, 5'd3, 1'b1, 4'h5, 32'h0000_0100);
    #1;
    check_vec("indep_id_ready", {31'd0, bus.id_ready}, 32'd1);
    check_vec("indep_raddr1", {27'd0, bus.rf_raddr1}, 32'd1);
    tick();
    bus.id_valid = 1'b0;
    check_vec("indep_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_vec("indep_ex_a", bus.ex_a, 32'd5);
    check_vec("indep_ex_b", bus.ex_b, 32'd7);
    check_vec("indep_ex_op", {28'd0, bus.ex_op}, 32'h5);
    check_vec("indep_ex_imm", bus.ex_imm, 32'h0000_0100);
    check_vec("indep_ex_rd", {27'd0, bus.ex_rd}, 32'd3);
    check_vec("indep_ex_rd_we", {31'd0, bus.ex_rd_we}, 32'd1);
    check_vec("indep_pending", dut.pending_q, 32'h0000_0008);

    // RAW stall on x3, released by same-cycle writeback with bypass.
    issue(5'd3, 5'd0, 5'd5, 1'b0, 4'h2, 32'd0);
    #1;
    check_vec("raw_stall0", {31'd0, bus.id_ready}, 32'd0);
    tick();
    check_vec("raw_drain_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_vec("raw_stall1", {31'd0, bus.id_ready}, 32'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h0000_DEAD;
    #1;
    check_vec("raw_release", {31'd0, bus.id_ready}, 32'd1);
    tick();
    bus.id_valid = 1'b0; bus.wb_valid = 1'b0;
    check_vec("raw_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_vec("raw_bypass_a", bus.ex_a, 32'h0000_DEAD);
    check_vec("raw_pending", dut.pending_q, 32'd0);

    // x0 source and destination.
    force_ones = 1'b1;
    issue(5'd0, 5'd1, 5'd0, 1'b1, 4'h1, 32'd0);
    #1;
    check_vec("x0_raddr2", {27'd0, bus.rf_raddr2}, 32'd1);
    tick();
    bus.id_valid = 1'b0;
    force_ones = 1'b0;
    check_vec("x0_ex_a", bus.ex_a, 32'd0);
    check_vec("x0_ex_b", bus.ex_b, 32'd5);
    check_vec("x0_ex_rd_we", {31'd0, bus.ex_rd_we}, 32'd0);
    check_vec("x0_pending", dut.pending_q, 32'd0);

    // Backpressure holds the output register, then back-to-back handoff.
    bus.ex_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd6, 1'b1, 4'h9, 32'h0000_0055);
    #1;
    check_vec("bp_id_ready", {31'd0, bus.id_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_vec("bp_hold_valid", {31'd0, bus.ex_valid}, 32'd1);
      check_vec("bp_hold_a", bus.ex_a, 32'd0);
      check_vec("bp_hold_b", bus.ex_b, 32'd5);
      check_vec("bp_hold_ready", {31'd0, bus.id_ready}, 32'd0);
    end
    bus.ex_ready = 1'b1;
    #1;
    check_vec("bp_release", {31'd0, bus.id_ready}, 32'd1);
    tick();
    bus.id_valid = 1'b0;
    check_vec("b2b_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_vec("b2b_ex_a", bus.ex_a, 32'd5);
    check_vec("b2b_ex_rd", {27'd0, bus.ex_rd}, 32'd6);
    check_vec("b2b_ex_op", {28'd0, bus.ex_op}, 32'h9);
    check_vec("b2b_pending", dut.pending_q, 32'h0000_0040);

    // WAW on x4 with set/clear collision.
    issue(5'd0, 5'd0, 5'd4, 1'b1, 4'h3, 32'd0);
    tick();
    check_vec("waw_setup_pending", dut.pending_q, 32'h0000_0050);
    issue(5'd1, 5'd2, 5'd4, 1'b1, 4'h4, 32'd0);
    #1;
    check_vec("waw_stall", {31'd0, bus.id_ready}, 32'd0);
    tick();
    check_vec("waw_stall_pending", dut.pending_q, 32'h0000_0050);
    check_vec("waw_stall_valid", {31'd0, bus.ex_valid}, 32'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h0000_0044;
    #1;
    check_vec("waw_release", {31'd0, bus.id_ready}, 32'd1);
    tick();
    bus.id_valid = 1'b0; bus.wb_valid = 1'b0;
    check_vec("waw_set_wins", dut.pending_q, 32'h0000_0050);
    check_vec("waw_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_vec("waw_ex_rd", {27'd0, bus.ex_rd}, 32'd4);
    check_vec("waw_ex_b", bus.ex_b, 32'd7);

    // Build pending = x3|x4 with ex_valid held, then reset asynchronously.
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'h0000_0066;
    issue(5'd0, 5'd0, 5'd3, 1'b1, 4'h7, 32'h0000_0777);
    tick();
    bus.id_valid = 1'b0; bus.wb_valid = 1'b0; bus.ex_ready = 1'b0;
    check_vec("pre_rst_pending", dut.pending_q, 32'h0000_0018);
    check_vec("pre_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_vec("arst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_vec("arst_ex_imm", bus.ex_imm, 32'd0);
    check_vec("arst_ex_rd", {27'd0, bus.ex_rd}, 32'd0);
    check_vec("arst_ex_op", {28'd0, bus.ex_op}, 32'd0);
    check_vec("arst_ex_rd_we", {31'd0, bus.ex_rd_we}, 32'd0);
    check_vec("arst_pending", dut.pending_q, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check_vec("post_rst_valid", {31'd0, bus.ex_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
Decode-to-execute pipeline stage between the instruction decoder and the ALU. It drives the register file read addresses, captures both operands with same-cycle writeback bypass, and tracks in-flight destination registers in a scoreboard to stall RAW/WAW hazards. It presents one registered instruction to execute over a valid/ready handshake.

Parameters:
XLEN, 32, datapath width (read data, writeback data, immediate, operands)
OP_W, 4, width of opaque ALU opcode field passed through

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
id_valid  input  1  decoder has an instruction
id_ready  output  1  stage accepts instruction this cycle
id_rs1  input  5  source register 1 index
id_rs2  input  5  source register 2 index
id_rd  input  5  destination register index
id_rd_we  input  1  instruction writes rd
id_op  input  OP_W  ALU opcode
id_imm  input  XLEN  immediate
rf_raddr1  output  5  register file read address 1 (= id_rs1, combinational)
rf_raddr2  output  5  register file read address 2 (= id_rs2, combinational)
rf_rdata1  input  XLEN  register file read data 1 (asynchronous read, x0 reads 0)
rf_rdata2  input  XLEN  register file read data 2
wb_valid  input  1  writeback this cycle (same signal as register file write enable)
wb_rd  input  5  writeback register index
wb_data  input  XLEN  writeback data
ex_valid  output  1  registered instruction valid to execute
ex_ready  input  1  execute accepts
ex_op  output  OP_W  registered opcode
ex_a  output  XLEN  registered operand 1
ex_b  output  XLEN  registered operand 2
ex_imm  output  XLEN  registered immediate
ex_rd  output  5  registered destination
ex_rd_we  output  1  registered write enable (0 when rd = x0)

Behaviour:
- Reset (async): ex_valid=0, ex_op/ex_a/ex_b/ex_imm/ex_rd/ex_rd_we=0, scoreboard pending[31:0]=0. Reset mid-operation discards the held instruction and all pending bits.
- Scoreboard: pending[r]=1 means an accepted instruction will write r and writeback has not yet occurred. pending[0] is constantly 0.
- clr = wb_valid && wb_rd!=0 → clears pending[wb_rd]. set = accept && id_rd_we && id_rd!=0 → sets pending[id_rd]. Next = (pending & ~clr) | set; set wins if same register.
- Hazard for source rsN (N=1,2): rsN!=0 && pending[rsN] && !(wb_valid && wb_rd==rsN). WAW hazard: id_rd_we && id_rd!=0 && pending[id_rd] && !(wb_valid && wb_rd==id_rd). Any hazard → stall. Sources are checked for both rs1 and rs2 regardless of instruction type.
- id_ready = !hazard && (!ex_valid || ex_ready). Combinational; no combinational path from id_valid to id_ready.
- accept = id_valid && id_ready. On accept, the output register loads on the next edge. Operand N = 0 if rsN==0. Otherwise operand N = wb_data if wb_valid && wb_rd==rsN (bypass, because the register file write lands at the same edge). Otherwise operand N = rf_rdataN.
- ex_rd_we = id_rd_we && id_rd!=0.
- Output register: ex_valid<=1 on accept. When ex_valid && ex_ready && !accept, ex_valid<=0. Output fields hold while ex_valid && !ex_ready. Latency is one cycle from accept to ex_valid; throughput is one instruction per cycle with no hazards.
- A stalled instruction must keep id_* stable (decoder contract). The stage does not latch stalled inputs.
- Simultaneous ex handoff and accept: the output register reloads and ex_valid stays 1.

Test Plan:
- Independent issue: after writebacks x1=5, x2=7, issue rs1=1 rs2=2 rd=3 ex_ready=1 → next cycle ex_valid=1, ex_a=5, ex_b=7, ex_rd_we=1, pending[3]=1.
- RAW stall + bypass: x3 pending; issue rs1=3 → id_ready=0 until the cycle with wb_valid=1, wb_rd=3, wb_data=0xDEAD, where id_ready=1 and the next ex_a=0xDEAD; pending[3]=0.
- x0 handling: rs1=0 with rf_rdata1=0xFFFF_FFFF forced, rd=0 id_rd_we=1 → ex_a=0, ex_rd_we=0, pending unchanged.
- Backpressure: ex_ready=0 with ex_valid=1 → id_ready=0 and ex_* stable for 3 cycles. Then ex_ready=1 with a new id_valid → back-to-back accept and ex_valid stays 1.
- WAW + set/clear collision: x4 pending, issue rd=4 → stall. In the cycle with wb_rd=4, accept occurs and pending[4] remains 1 (set wins).
- Async reset while ex_valid=1 and pending=0x0000_0018 → immediately ex_valid=0, all ex_* outputs 0, pending=0.
